// File: rtl/sr04_scan_scheduler_if.sv
// Bundle of control, engine-handshake and read-port signals shared between the
// SR04 scan scheduler (slave side) and whatever hosts it (master side).
// The interface parameters must match the scheduler's N_CH / DIST_W.
interface sr04_scan_scheduler_if #(
    parameter int N_CH   = 4,
    parameter int DIST_W = 9
);
    localparam int SEL_W = $clog2(N_CH);

    // scan control
    logic              en;
    logic [N_CH-1:0]   ch_mask;
    // engine handshake and sensor mux
    logic              start;
    logic [SEL_W-1:0]  sel;
    logic              busy;
    logic              meas_done;
    logic              meas_valid;
    logic [DIST_W-1:0] meas_dist;
    // result read port
    logic [SEL_W-1:0]  rd_ch;
    logic              rd_ack;
    logic [DIST_W-1:0] rd_dist;
    logic              rd_fresh;
    logic              rd_err;
    logic              frame;

    modport master (
        output en, ch_mask, meas_done, meas_valid, meas_dist, rd_ch, rd_ack,
        input  start, sel, busy, rd_dist, rd_fresh, rd_err, frame
    );

    modport slave (
        input  en, ch_mask, meas_done, meas_valid, meas_dist, rd_ch, rd_ack,
        output start, sel, busy, rd_dist, rd_fresh, rd_err, frame
    );
endinterface

// File: rtl/sr04_scan_scheduler.sv
// Round-robin scheduler sharing one SR04 measurement engine among N_CH sensors.
// Picks the next enabled channel, fires the engine, waits for done or the
// watchdog, then idles for a guard gap so echoes from different sensors never
// overlap. The last result of every channel is kept in a small register file.
module sr04_scan_scheduler #(
    parameter int N_CH      = 4,
    parameter int DIST_W    = 9,
    parameter int GUARD_CYC = 6000000,
    parameter int WDOG_CYC  = 6500000
) (
    input logic                   clk,
    input logic                   rst,
    sr04_scan_scheduler_if.slave  bus
);
    localparam int SEL_W   = $clog2(N_CH);
    localparam int MAX_CYC = (GUARD_CYC > WDOG_CYC) ? GUARD_CYC : WDOG_CYC;
    // Sized so the longer of the two waits never wraps.
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_START,
        ST_BUSY,
        ST_GUARD
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  pick_ch;
    logic [SEL_W-1:0]  cand;
    logic              found;
    logic [SEL_W-1:0]  top_ch;
    logic [CNT_W-1:0]  wdog_q;
    logic [CNT_W-1:0]  guard_q;
    logic              frame_q;
    logic              scan_go;
    logic              wdog_exp;
    logic              guard_end;
    logic              complete;
    logic [DIST_W-1:0] dist_q [N_CH];
    logic [N_CH-1:0]   fresh_q;
    logic [N_CH-1:0]   err_q;

    assign scan_go   = bus.en && (|bus.ch_mask);
    assign wdog_exp  = (wdog_q == CNT_W'(WDOG_CYC - 1));
    assign guard_end = (guard_q == CNT_W'(GUARD_CYC - 1));

    // Next channel: first mask bit found scanning upward from ptr+1, wrapping.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        pick_ch = ptr_q;
        cand    = ptr_q;
        found   = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = SEL_W'((int'(ptr_q) + i) % N_CH);
            if (!found && bus.ch_mask[cand]) begin
                pick_ch = cand;
                found   = 1'b1;
            end
        end
    end

    // Highest enabled channel marks the end of a scan frame.
    always_comb begin
        top_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.ch_mask[i]) top_ch = SEL_W'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; complete flags the cycle a measurement ends (done or watchdog).
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        case (state_q)
            ST_IDLE:  if (scan_go) state_d = ST_PICK;
            ST_PICK:  state_d = scan_go ? ST_START : ST_IDLE;
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.meas_done || wdog_exp) begin
                    complete = 1'b1;
                    state_d  = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (guard_end) state_d = scan_go ? ST_PICK : ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Channel pointer and mux select only move in PICK, keeping sel stable through GUARD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= SEL_W'(N_CH - 1);
            sel_q <= '0;
        end else if (state_q == ST_PICK && scan_go) begin
            ptr_q <= pick_ch;
            sel_q <= pick_ch;
        end
    end

    // Watchdog and guard counters, plus the end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q  <= '0;
            guard_q <= '0;
            frame_q <= 1'b0;
        end else begin
            if (state_q == ST_START)                wdog_q <= '0;
            else if (state_q == ST_BUSY && !complete) wdog_q <= wdog_q + 1'b1;

            if (complete)                  guard_q <= '0;
            else if (state_q == ST_GUARD)  guard_q <= guard_q + 1'b1;

            frame_q <= complete && (sel_q == top_ch);
        end
    end

    // Per-channel result storage; engine results are only accepted in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the result file is reset explicitly because consumers may read it before the first scan.
        if (rst) begin
            for (int i = 0; i < N_CH; i++) dist_q[i] <= '0;
            fresh_q <= '0;
            err_q   <= '0;
        end else begin
            if (bus.rd_ack) fresh_q[bus.rd_ch] <= 1'b0;
            // NOTE: a later non-blocking assignment to the same bit wins, so a fresh write overrides an ack.
            if (state_q == ST_BUSY) begin
                if (bus.meas_done && bus.meas_valid) begin
                    dist_q[sel_q]  <= bus.meas_dist;
                    fresh_q[sel_q] <= 1'b1;
                    err_q[sel_q]   <= 1'b0;
                end else if (bus.meas_done || wdog_exp) begin
                    err_q[sel_q]   <= 1'b1;
                end
            end
        end
    end

    assign bus.start    = (state_q == ST_START);
    assign bus.busy     = (state_q == ST_START) || (state_q == ST_BUSY) || (state_q == ST_GUARD);
    assign bus.sel      = sel_q;
    assign bus.frame    = frame_q;
    assign bus.rd_dist  = dist_q[bus.rd_ch];
    assign bus.rd_fresh = fresh_q[bus.rd_ch];
    assign bus.rd_err   = err_q[bus.rd_ch];
endmodule

// File: tb/tb_sr04_scan_scheduler.sv
// Self-checking bench for sr04_scan_scheduler: directed scenarios plus a
// randomized stretch, checked against a channel-level model of the scan order
// and the per-channel result file.
module tb_sr04_scan_scheduler;
    localparam int N_CH   = 4;
    localparam int DIST_W = 9;
    localparam int GUARD  = 8;
    localparam int WDOG   = 20;
    localparam int SW     = $clog2(N_CH);

    typedef logic [SW-1:0] ch_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sr04_scan_scheduler_if #(.N_CH(N_CH), .DIST_W(DIST_W)) bus ();

    sr04_scan_scheduler #(
        .N_CH(N_CH), .DIST_W(DIST_W), .GUARD_CYC(GUARD), .WDOG_CYC(WDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [DIST_W-1:0] m_dist  [N_CH];
    bit                m_fresh [N_CH];
    bit                m_err   [N_CH];
    ch_t               last_ch;
    ch_t               exp_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ch_t next_ch(input ch_t last, input logic [N_CH-1:0] m);
        ch_t c;
        for (int i = 1; i <= N_CH; i++) begin
            c = ch_t'((int'(last) + i) % N_CH);
            if (m[c]) return c;
        end
        return last;
    endfunction

    function automatic ch_t top_of(input logic [N_CH-1:0] m);
        ch_t t = '0;
        for (int i = 0; i < N_CH; i++) if (m[i]) t = ch_t'(i);
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_dist[i]  = '0;
            m_fresh[i] = 1'b0;
            m_err[i]   = 1'b0;
        end
        last_ch = ch_t'(N_CH - 1);
    endtask

    task automatic check_rd(input ch_t ch, input string tag);
        bus.rd_ch = ch;
        #1;
        chk({tag, "_dist"},  32'(bus.rd_dist),  32'(m_dist[ch]));
        chk({tag, "_fresh"}, 32'(bus.rd_fresh), 32'(m_fresh[ch]));
        chk({tag, "_err"},   32'(bus.rd_err),   32'(m_err[ch]));
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N_CH; i++) check_rd(ch_t'(i), tag);
    endtask

    // Wait (bounded) for a start pulse; check latency and the selected channel.
    task automatic expect_start(input int lat, input string tag);
        int n = 0;
        exp_ch  = next_ch(last_ch, bus.ch_mask);
        last_ch = exp_ch;
        while (bus.start !== 1'b1 && n < 4 * (GUARD + WDOG)) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_sel"}, 32'(bus.sel), 32'(exp_ch));
    endtask

    // Play the engine for one measurement, starting in the START cycle.
    task automatic ping(input int k, input bit give_done, input bit valid,
                        input logic [DIST_W-1:0] d, input bit drop_en,
                        input bit ack_same, input string tag);
        ch_t ch = exp_ch;
        tick();
        chk({tag, "_start_1cyc"}, 32'(bus.start), 32'(0));
        if (drop_en) bus.en = 1'b0;
        if (give_done) begin
            repeat (k) tick();
            bus.meas_done  = 1'b1;
            bus.meas_valid = valid;
            bus.meas_dist  = d;
            if (ack_same) begin
                bus.rd_ack = 1'b1;
                bus.rd_ch  = ch;
            end
            tick();
            bus.meas_done  = 1'b0;
            bus.meas_valid = 1'b0;
            bus.meas_dist  = DIST_W'($urandom_range(0, 511));
            bus.rd_ack     = 1'b0;
            if (valid) begin
                m_dist[ch]  = d;
                m_fresh[ch] = 1'b1;
                m_err[ch]   = 1'b0;
            end else begin
                m_err[ch]   = 1'b1;
            end
        end else begin
            repeat (WDOG - 1) tick();
            check_rd(ch, {tag, "_pre_wdog"});
            tick();
            m_err[ch] = 1'b1;
        end
        chk({tag, "_frame"}, 32'(bus.frame), 32'(ch == top_of(bus.ch_mask)));
        chk({tag, "_busy"},  32'(bus.busy),  32'(1));
        check_rd(ch, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int starts;
        int lat;
        logic [N_CH-1:0] new_mask;
        ch_t ack_ch;

        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.ch_mask    = '0;
        bus.meas_done  = 1'b0;
        bus.meas_valid = 1'b0;
        bus.meas_dist  = '0;
        bus.rd_ch      = '0;
        bus.rd_ack     = 1'b0;
        model_reset();
        repeat (3) tick();

        // reset state
        chk("rst_start", 32'(bus.start), 32'(0));
        chk("rst_busy",  32'(bus.busy),  32'(0));
        chk("rst_frame", 32'(bus.frame), 32'(0));
        chk("rst_sel",   32'(bus.sel),   32'(0));
        check_all("rst_regs");
        rst = 1'b0;
        tick();

        // scenario 1: full mask, first pick is ch0, guard gap to ch1
        bus.ch_mask = 4'b1111;
        bus.en      = 1'b1;
        expect_start(2, "s1_first");
        ping(3, 1'b1, 1'b1, 9'd123, 1'b0, 1'b0, "s1_ch0");
        expect_start(GUARD + 1, "s1_ch1");
        ping($urandom_range(0, WDOG - 1), 1'b1, 1'b1, DIST_W'($urandom_range(0, 400)), 1'b0, 1'b0, "s1_ch1p");
        expect_start(GUARD + 1, "s1_ch2");
        ping($urandom_range(0, WDOG - 1), 1'b1, 1'b1, DIST_W'($urandom_range(0, 400)), 1'b0, 1'b0, "s1_ch2p");
        expect_start(GUARD + 1, "s1_ch3");
        ping(WDOG - 1, 1'b1, 1'b1, 9'd400, 1'b0, 1'b0, "s1_ch3p");

        // scenario 2: sparse mask, sequence 1,3,1,3 with frame only after ch3
        bus.ch_mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            expect_start(GUARD + 1, "s2_start");
            ping($urandom_range(0, WDOG - 1), 1'b1, 1'b1, DIST_W'($urandom_range(0, 400)), 1'b0, 1'b0, "s2_ping");
        end

        // scenario 3: watchdog on ch1, scan moves on to ch3
        expect_start(GUARD + 1, "s3_start");
        ping(0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "s3_wdog");
        expect_start(GUARD + 1, "s3_next");
        ping(5, 1'b1, 1'b1, 9'd222, 1'b0, 1'b0, "s3_ch3");

        // scenario 4: single-bit mask repeats ch2; invalid keeps old distance
        bus.ch_mask = 4'b0100;
        expect_start(GUARD + 1, "s4_a");
        ping(2, 1'b1, 1'b1, 9'd50, 1'b0, 1'b0, "s4_d50");
        expect_start(GUARD + 1, "s4_b");
        ping(4, 1'b1, 1'b0, 9'd300, 1'b0, 1'b0, "s4_inv");
        expect_start(GUARD + 1, "s4_c");
        ping(1, 1'b1, 1'b1, 9'd77, 1'b0, 1'b0, "s4_d77");

        // randomized stretch: masks, outcomes and acks vary each round
        for (int i = 0; i < 12; i++) begin
            new_mask    = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            bus.ch_mask = new_mask;
            lat = GUARD + 1;
            if ($urandom_range(0, 1) == 1) begin
                ack_ch     = ch_t'($urandom_range(0, N_CH - 1));
                bus.rd_ch  = ack_ch;
                bus.rd_ack = 1'b1;
                tick();
                bus.rd_ack = 1'b0;
                m_fresh[ack_ch] = 1'b0;
                lat = GUARD;
            end
            expect_start(lat, "rnd_start");
            ping($urandom_range(0, WDOG - 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 DIST_W'($urandom_range(0, 400)), 1'b0, 1'b0, "rnd_ping");
        end
        check_all("rnd_regs");

        // scenario 5: en dropped during BUSY; result kept, then IDLE, no more starts
        bus.ch_mask = 4'b1111;
        expect_start(GUARD + 1, "s5_start");
        ping(6, 1'b1, 1'b1, 9'd311, 1'b1, 1'b0, "s5_drop");
        repeat (GUARD - 1) tick();
        chk("s5_busy_guard", 32'(bus.busy), 32'(1));
        tick();
        chk("s5_busy_idle", 32'(bus.busy), 32'(0));
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.start === 1'b1) starts++;
        end
        chk("s5_no_start", 32'(starts), 32'(0));

        // scenario 6: ack collides with a fresh write on ch0; write wins
        bus.ch_mask = 4'b0001;
        bus.en      = 1'b1;
        expect_start(2, "s6_start");
        ping(3, 1'b1, 1'b1, 9'd199, 1'b0, 1'b1, "s6_collide");
        bus.rd_ch  = '0;
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        m_fresh[0] = 1'b0;
        check_rd('0, "s6_ack");

        // async reset in the middle of BUSY on ch3
        bus.ch_mask = 4'b1000;
        expect_start(GUARD, "s6_rst_start");
        tick();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_start", 32'(bus.start), 32'(0));
        chk("arst_busy",  32'(bus.busy),  32'(0));
        chk("arst_frame", 32'(bus.frame), 32'(0));
        chk("arst_sel",   32'(bus.sel),   32'(0));
        check_all("arst_regs");
        tick();
        bus.ch_mask = 4'b1111;
        rst = 1'b0;
        expect_start(2, "post_rst");
        ping(8, 1'b1, 1'b1, 9'd42, 1'b0, 1'b0, "post_rst_p");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
